// File: rtl/q_meter_pkg.sv
// Shared front-end control definitions for the Q measurement responder.
package q_meter_pkg;

    localparam int QM_BUS_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_DONE    = 2'd3
    } qm_state_t;

endpackage

// File: rtl/q_meter_acc.sv
// q_avg_acc: sums 2**LOG2_AVG unsigned samples and flags when the set is complete.
module q_avg_acc
    import q_meter_pkg::*;
#(
    parameter int BUS_WIDTH = QM_BUS_WIDTH,
    parameter int LOG2_AVG  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clear,
    input  logic                          i_valid,
    input  logic [BUS_WIDTH-1:0]          i_data,
    output logic [BUS_WIDTH+LOG2_AVG-1:0] o_sum,
    output logic                          o_done
);

    localparam int SW = BUS_WIDTH + LOG2_AVG;
    localparam int CW = LOG2_AVG + 1;

    logic [SW-1:0] r_sum;
    logic [CW-1:0] r_cnt;
    logic          r_done;

    // Samples arriving after the set is complete are dropped so the sum stays exact.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sum  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_valid && !r_done) begin
            r_sum <= r_sum + SW'(i_data);
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'((1 << LOG2_AVG) - 1))
                r_done <= 1'b1;
        end
    end

    assign o_sum  = r_sum;
    assign o_done = r_done;

endmodule

// File: rtl/q_meter.sv
// q_meter: settle, average and report Q for each new i_ref from the bisection loop.
// Optional watchdog on missing ADC strobes is built when QMETER_TIMEOUT_EN is defined.
module q_meter
    import q_meter_pkg::*;
#(
    parameter int BUS_WIDTH      = QM_BUS_WIDTH,
    parameter int LOG2_AVG       = 2,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic                 adc_valid,
    input  logic [BUS_WIDTH-1:0] adc_data,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 busy,
`ifdef QMETER_TIMEOUT_EN
    output logic                 timeout,
`endif
    output logic [1:0]           o_dbg_state
);

    // Handshake: adc_valid is a one-cycle strobe with no back-pressure; a sample is
    // consumed in any ACQUIRE cycle where it is high. ready is a one-cycle strobe
    // coincident with the q_measured update; the consumer cannot stall it.

    localparam int SW  = BUS_WIDTH + LOG2_AVG;
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);

    qm_state_t            r_state;
    logic [BUS_WIDTH-1:0] r_q_measured;
    logic                 r_ready;
    logic                 r_busy;
    logic [BUS_WIDTH-1:0] r_i_ref_last;
    logic                 r_first_pending;
    logic [SCW-1:0]       r_settle_cnt;

`ifdef QMETER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wdog;
    logic          r_timeout;
`endif

    logic          w_ref_changed;
    logic          w_trigger;
    logic          w_restart;
    logic          w_acc_valid;
    logic [SW-1:0] w_sum;
    logic          w_done;

    assign w_ref_changed = (i_ref != r_i_ref_last);
    assign w_trigger     = enable && (w_ref_changed || r_first_pending);
    // A trigger in IDLE and a mid-measurement abort both start a fresh SETTLE.
    assign w_restart     = ((r_state == ST_IDLE) && w_trigger) ||
                           (enable && w_ref_changed &&
                            ((r_state == ST_SETTLE) || (r_state == ST_ACQUIRE)));
    assign w_acc_valid   = adc_valid && (r_state == ST_ACQUIRE);

    q_avg_acc #(
        .BUS_WIDTH (BUS_WIDTH),
        .LOG2_AVG  (LOG2_AVG)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_restart),
        .i_valid (w_acc_valid),
        .i_data  (adc_data),
        .o_sum   (w_sum),
        .o_done  (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_q_measured    <= '0;
            r_ready         <= 1'b0;
            r_busy          <= 1'b0;
            r_i_ref_last    <= '0;
            r_first_pending <= 1'b1;
            r_settle_cnt    <= '0;
`ifdef QMETER_TIMEOUT_EN
            r_wdog          <= '0;
            r_timeout       <= 1'b0;
`endif
        end else if (!enable) begin
            r_state         <= ST_IDLE;
            r_ready         <= 1'b0;
            r_busy          <= 1'b0;
            r_first_pending <= 1'b1;
        end else begin
            r_ready <= 1'b0;
            if (w_restart) begin
                r_i_ref_last    <= i_ref;
                r_first_pending <= 1'b0;
                r_settle_cnt    <= '0;
                r_state         <= ST_SETTLE;
                r_busy          <= 1'b1;
            end else begin
                case (r_state)
                    ST_SETTLE: begin
                        if (r_settle_cnt == SCW'(SETTLE_CYCLES - 1)) begin
                            r_state <= ST_ACQUIRE;
`ifdef QMETER_TIMEOUT_EN
                            r_wdog  <= '0;
`endif
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (w_done) begin
                            r_state      <= ST_DONE;
                            r_busy       <= 1'b0;
                            r_ready      <= 1'b1;
                            r_q_measured <= w_sum[LOG2_AVG +: BUS_WIDTH];
                        end
`ifdef QMETER_TIMEOUT_EN
                        else if (adc_valid) begin
                            r_wdog <= '0;
                        end else if (r_wdog == TW'(TIMEOUT_CYCLES - 1)) begin
                            r_timeout       <= 1'b1;
                            r_state         <= ST_IDLE;
                            r_busy          <= 1'b0;
                            r_first_pending <= 1'b1;
                        end else begin
                            r_wdog <= r_wdog + 1'b1;
                        end
`endif
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign q_measured  = r_q_measured;
    assign ready       = r_ready;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;
`ifdef QMETER_TIMEOUT_EN
    assign timeout     = r_timeout;
`endif

endmodule

// File: tb/tb_q_meter.sv
// Directed bench for q_meter: scoreboard of expected averages checked on each ready pulse.
module tb_q_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] i_ref = '0;
  logic       adc_valid = 1'b0;
  logic [9:0] adc_data = '0;
  logic [9:0] q_measured;
  logic       ready;
  logic       busy;
  logic [1:0] dbg_state;
`ifdef QMETER_TIMEOUT_EN
  logic       timeout;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int last_ready_cyc = 0;
  logic [9:0] exp_q[$];

  q_meter #(
    .BUS_WIDTH(10),
    .LOG2_AVG(2),
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .i_ref(i_ref),
    .adc_valid(adc_valid),
    .adc_data(adc_data),
    .q_measured(q_measured),
    .ready(ready),
    .busy(busy),
`ifdef QMETER_TIMEOUT_EN
    .timeout(timeout),
`endif
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // scoreboard: every ready pulse must match the oldest expected result
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      ready_cnt++;
      last_ready_cyc = cyc;
      if (exp_q.size() == 0)
        check("ready_unexpected", 32'(ready), 32'd0);
      else
        check("q_measured", 32'(q_measured), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    step();
  endtask

  task automatic run_meas(input logic [9:0] r, input logic [9:0] a, input logic [9:0] b,
                          input logic [9:0] c, input logic [9:0] d, input logic [9:0] e,
                          input logic junk);
    int t0;
    int n0;
    i_ref = r;
    adc_valid = 1'b0;
    step();
    t0 = cyc;
    check("busy_after_trigger", 32'(busy), 32'd1);
    repeat (4) begin
      adc_valid = junk;
      adc_data  = 10'd777;
      step();
    end
    exp_q.push_back(e);
    n0 = ready_cnt;
    send(a); send(b); send(c); send(d);
    adc_valid = 1'b0;
    for (int i = 0; i < 20 && ready_cnt == n0; i++) step();
    check("ready_count", 32'(ready_cnt), 32'(n0 + 1));
    check("latency", 32'(last_ready_cyc - t0), 32'd9);
    check("busy_after_done", 32'(busy), 32'd0);
    check("q_held", 32'(q_measured), 32'(e));
  endtask

  initial begin
    int n0;
    int n;
    // reset state
    repeat (3) step();
    check("rst_q", 32'(q_measured), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    enable = 1'b1;

    // first measurement, then truncation with junk strobes during settle
    run_meas(10'd512, 10'd100, 10'd102, 10'd104, 10'd106, 10'd103, 1'b0);
    run_meas(10'd300, 10'd1023, 10'd1023, 10'd1023, 10'd1022, 10'd1022, 1'b1);
    run_meas(10'd301, 10'd0, 10'd0, 10'd0, 10'd3, 10'd0, 1'b1);

    // abort after two samples, restart on the new reference
    i_ref = 10'd512;
    step();
    repeat (4) step();
    send(10'd11); send(10'd22);
    n0 = ready_cnt;
    run_meas(10'd256, 10'd40, 10'd40, 10'd40, 10'd40, 10'd40, 1'b0);
    check("abort_single_ready", 32'(ready_cnt), 32'(n0 + 1));

    // unchanged reference: no new measurement
    n0 = ready_cnt;
    for (int i = 0; i < 50; i++) begin
      adc_valid = 1'($urandom_range(0, 1));
      adc_data  = 10'($urandom_range(0, 1023));
      step();
      check("idle_busy", 32'(busy), 32'd0);
    end
    adc_valid = 1'b0;
    check("idle_no_ready", 32'(ready_cnt), 32'(n0));

    // enable drop during SETTLE, then re-enable with the same reference
    i_ref = 10'd100;
    step();
    step(); step();
    enable = 1'b0;
    step();
    check("dis_busy", 32'(busy), 32'd0);
    check("dis_state", 32'(dbg_state), 32'd0);
    check("dis_q_hold", 32'(q_measured), 32'd40);
    repeat (3) step();
    check("dis_no_ready", 32'(ready_cnt), 32'(n0));
    enable = 1'b1;
    run_meas(10'd100, 10'd10, 10'd20, 10'd30, 10'd40, 10'd25, 1'b0);

    // synchronous reset during ACQUIRE
    i_ref = 10'd200;
    step();
    repeat (4) step();
    send(10'd5);
    adc_valid = 1'b0;
    rst = 1'b1;
    step();
    check("mid_rst_q", 32'(q_measured), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    run_meas(10'd200, 10'd7, 10'd7, 10'd7, 10'd7, 10'd7, 1'b0);

`ifdef QMETER_TIMEOUT_EN
    // watchdog: one sample then silence
    n0 = ready_cnt;
    i_ref = 10'd333;
    step();
    repeat (4) step();
    send(10'd5);
    adc_valid = 1'b0;
    n = 0;
    for (int i = 1; i <= 20 && timeout !== 1'b1; i++) begin
      step();
      n = i;
    end
    check("timeout_cycles", 32'(n), 32'd8);
    check("timeout_flag", 32'(timeout), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_no_ready", 32'(ready_cnt), 32'(n0));
    run_meas(10'd333, 10'd9, 10'd9, 10'd9, 10'd9, 10'd9, 1'b0);
    check("timeout_sticky", 32'(timeout), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("timeout_rst", 32'(timeout), 32'd0);
`endif

    repeat (3) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
